// File: rtl/hazard_pkg.sv
// Shared constants and types for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned MAX_LAT    = 4;
  localparam int unsigned LAT_W      = 3;

  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;
  localparam int unsigned LAT_MUL  = 3;

  typedef logic [LAT_W-1:0] lat_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard; stats ports exist only with HAZARD_STATS_EN.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int unsigned NumRegs  = NUM_REGS,
  parameter int unsigned RegAddrW = REG_ADDR_W,
  parameter int unsigned LatW     = LAT_W
) ();

  logic                IssueValidD;
  logic                RegWriteEnD;
  logic [RegAddrW-1:0] RdD;
  logic [RegAddrW-1:0] Rs1D;
  logic [RegAddrW-1:0] Rs2D;
  logic                Rs1UsedD;
  logic                Rs2UsedD;
  logic [LatW-1:0]     LatClassD;
  logic                BranchTakenD;

  logic                PCWriteF;
  logic                IF_IDWriteF;
  logic                IF_IDFlushF;
  logic                ID_EXBubbleE;
  logic                StallD;
  logic [NumRegs-1:0]  BusyVec;
`ifdef HAZARD_STATS_EN
  logic [31:0]         StallCycles;
  logic [31:0]         FlushCount;
`endif

  modport master (
    output IssueValidD, RegWriteEnD, RdD, Rs1D, Rs2D, Rs1UsedD, Rs2UsedD, LatClassD,
    output BranchTakenD,
    input  PCWriteF, IF_IDWriteF, IF_IDFlushF, ID_EXBubbleE, StallD, BusyVec
`ifdef HAZARD_STATS_EN
    , input StallCycles, FlushCount
`endif
  );

  modport slave (
    input  IssueValidD, RegWriteEnD, RdD, Rs1D, Rs2D, Rs1UsedD, Rs2UsedD, LatClassD,
    input  BranchTakenD,
    output PCWriteF, IF_IDWriteF, IF_IDFlushF, ID_EXBubbleE, StallD, BusyVec
`ifdef HAZARD_STATS_EN
    , output StallCycles, FlushCount
`endif
  );

endinterface

// File: rtl/hazard_reg_counter.sv
// Per-register countdown of cycles until a pending result becomes forwardable.
module hazard_reg_counter
  import hazard_pkg::*;
#(
  parameter int unsigned LatW = LAT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [LatW-1:0] load_val,
  output logic            busy
);

  logic [LatW-1:0] count_q, count_d;

  // A new writer overrides the decrement on the same edge.
  always_comb begin
    count_d = count_q;
    if (load_en) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - LatW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register latency scoreboard driving stall, flush and bubble.
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NumRegs  = NUM_REGS,
  parameter int unsigned RegAddrW = REG_ADDR_W,
  parameter int unsigned MaxLat   = MAX_LAT,
  parameter int unsigned LatW     = LAT_W
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave hif
);

  localparam logic [LatW-1:0] MaxLatV = LatW'(MaxLat);

  logic [NumRegs-1:0] busy;
  logic [LatW-1:0]    lat_clamped;
  logic               rs1_haz, rs2_haz;
  logic               stall, issue, wr_en, flush;

  assign busy[0] = 1'b0;

  // Hazard lookups see only the pre-edge state, so an instruction reading its own Rd
  // is not blocked by itself.
  assign rs1_haz = hif.IssueValidD & hif.Rs1UsedD & (hif.Rs1D != '0) & busy[hif.Rs1D];
  assign rs2_haz = hif.IssueValidD & hif.Rs2UsedD & (hif.Rs2D != '0) & busy[hif.Rs2D];

  assign stall       = ~rst & (rs1_haz | rs2_haz);
  assign issue       = ~rst & hif.IssueValidD & ~stall;
  assign wr_en       = issue & hif.RegWriteEnD & (hif.RdD != '0);
  assign flush       = hif.BranchTakenD & issue;
  assign lat_clamped = (hif.LatClassD > MaxLatV) ? MaxLatV : hif.LatClassD;

  for (genvar r = 1; r < NumRegs; r++) begin : g_reg
    hazard_reg_counter #(
      .LatW(LatW)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .load_en (wr_en && (hif.RdD == RegAddrW'(r))),
      .load_val(lat_clamped),
      .busy    (busy[r])
    );
  end

  assign hif.StallD       = stall;
  assign hif.PCWriteF     = ~rst & ~stall;
  assign hif.IF_IDWriteF  = ~rst & ~stall;
  assign hif.ID_EXBubbleE = rst | stall;
  assign hif.IF_IDFlushF  = rst | flush;
  assign hif.BusyVec      = rst ? '0 : busy;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating: the counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign hif.StallCycles = stall_cnt_q;
  assign hif.FlushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// compared against a per-register countdown model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if hif ();

  hazard_scoreboard dut (
    .clk(clk),
    .rst(rst),
    .hif(hif)
  );

  int total = 0;
  int bad   = 0;
  int pend_m [NUM_REGS];
  int stall_m = 0;
  int flush_m = 0;

  task automatic drive(input bit v, input bit we, input int rd, input int rs1, input bit u1,
                       input int rs2, input bit u2, input int lat, input bit br);
    hif.IssueValidD  = v;
    hif.RegWriteEnD  = we;
    hif.RdD          = REG_ADDR_W'(rd);
    hif.Rs1D         = REG_ADDR_W'(rs1);
    hif.Rs1UsedD     = u1;
    hif.Rs2D         = REG_ADDR_W'(rs2);
    hif.Rs2UsedD     = u2;
    hif.LatClassD    = LAT_W'(lat);
    hif.BranchTakenD = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic bit model_stall();
    bit h1, h2;
    if (rst) return 1'b0;
    h1 = hif.Rs1UsedD && (hif.Rs1D != 0) && (pend_m[hif.Rs1D] > 0);
    h2 = hif.Rs2UsedD && (hif.Rs2D != 0) && (pend_m[hif.Rs2D] > 0);
    return hif.IssueValidD && (h1 || h2);
  endfunction

  function automatic logic [NUM_REGS-1:0] model_busy();
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int r = 0; r < NUM_REGS; r++) v[r] = !rst && (pend_m[r] != 0);
    return v;
  endfunction

  // Applies one clock edge to the model, then lets the DUT take the same edge.
  task automatic advance();
    bit st, iss;
    int lat;
    st  = model_stall();
    iss = !rst && hif.IssueValidD && !st;
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) pend_m[r] = 0;
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (st) stall_m++;
      if (iss && hif.BranchTakenD) flush_m++;
      for (int r = 0; r < NUM_REGS; r++) if (pend_m[r] > 0) pend_m[r]--;
      lat = int'(hif.LatClassD);
      if (iss && hif.RegWriteEnD && hif.RdD != 0)
        pend_m[hif.RdD] = (lat > int'(MAX_LAT)) ? int'(MAX_LAT) : lat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1, 1, 3, 3, 1, 0, 0, 3, 1);
      @(negedge clk);
      total++;
      if ({hif.StallD, hif.PCWriteF, hif.IF_IDWriteF, hif.ID_EXBubbleE, hif.IF_IDFlushF}
          !== 5'b00011) begin
        bad++;
        $display("FAIL reset_outputs: got %b want 00011",
                 {hif.StallD, hif.PCWriteF, hif.IF_IDWriteF, hif.ID_EXBubbleE, hif.IF_IDFlushF});
      end
      total++;
      if (hif.BusyVec !== '0) begin
        bad++;
        $display("FAIL reset_busy: got %h want 0", hif.BusyVec);
      end
      advance();
    end
    rst = 1'b0;
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if ({hif.PCWriteF, hif.StallD} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release: pcwrite/stall got %b want 10", {hif.PCWriteF, hif.StallD});
    end
    advance();
    idle();
  endtask

  task automatic test_load_use();
    drive(1, 1, 5, 1, 1, 2, 1, LAT_LOAD, 0);
    @(negedge clk);
    total++;
    if (hif.StallD !== 1'b0) begin
      bad++;
      $display("FAIL lu_load_issue: stall got %b want 0", hif.StallD);
    end
    advance();
    drive(1, 1, 6, 5, 1, 1, 1, LAT_ALU, 0);
    @(negedge clk);
    total++;
    if ({hif.StallD, hif.ID_EXBubbleE, hif.PCWriteF, hif.BusyVec[5]} !== 4'b1101) begin
      bad++;
      $display("FAIL lu_stall: stall/bubble/pcw/busy5 got %b want 1101",
               {hif.StallD, hif.ID_EXBubbleE, hif.PCWriteF, hif.BusyVec[5]});
    end
    advance();
    @(negedge clk);
    total++;
    if ({hif.StallD, hif.ID_EXBubbleE} !== 2'b00) begin
      bad++;
      $display("FAIL lu_issue: stall/bubble got %b want 00", {hif.StallD, hif.ID_EXBubbleE});
    end
    advance();
    idle();
  endtask

  task automatic test_x0();
    drive(1, 1, 0, 1, 0, 0, 0, LAT_MUL, 0);
    advance();
    drive(1, 0, 0, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    total++;
    if ({hif.StallD, hif.BusyVec} !== {1'b0, {NUM_REGS{1'b0}}}) begin
      bad++;
      $display("FAIL x0_never_busy: stall %b busy %h want 0/0", hif.StallD, hif.BusyVec);
    end
    advance();
    idle();
  endtask

  task automatic test_mul_latency();
    int lats [2] = '{3, 7};
    for (int k = 0; k < 2; k++) begin
      int n, exp_n;
      exp_n = (lats[k] > int'(MAX_LAT)) ? int'(MAX_LAT) : lats[k];
      n = 0;
      drive(1, 1, 7, 1, 1, 2, 0, lats[k], 0);
      advance();
      drive(1, 1, 8, 3, 1, 7, 1, LAT_ALU, 0);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (!hif.StallD) break;
        n++;
        advance();
      end
      total++;
      if (n !== exp_n) begin
        bad++;
        $display("FAIL mul_stall_len lat=%0d: stalled %0d cycles want %0d", lats[k], n, exp_n);
      end
      advance();
      idle();
      repeat (5) advance();
    end
  endtask

  task automatic test_branch();
    drive(1, 1, 9, 0, 0, 0, 0, LAT_LOAD, 0);
    advance();
    drive(1, 0, 0, 9, 1, 2, 1, 0, 1);
    @(negedge clk);
    total++;
    if ({hif.StallD, hif.IF_IDFlushF} !== 2'b10) begin
      bad++;
      $display("FAIL br_stalled: stall/flush got %b want 10", {hif.StallD, hif.IF_IDFlushF});
    end
    advance();
    @(negedge clk);
    total++;
    if ({hif.StallD, hif.IF_IDFlushF} !== 2'b01) begin
      bad++;
      $display("FAIL br_issue: stall/flush got %b want 01", {hif.StallD, hif.IF_IDFlushF});
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    total++;
    if ({hif.IF_IDFlushF, hif.PCWriteF} !== 2'b01) begin
      bad++;
      $display("FAIL br_invalid: flush/pcw got %b want 01", {hif.IF_IDFlushF, hif.PCWriteF});
    end
    advance();
    idle();
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 7, 0, 0, 0, 0, LAT_MUL, 0);
    advance();
    idle();
    advance();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (hif.BusyVec !== '0) begin
      bad++;
      $display("FAIL midrst_busy: got %h want 0", hif.BusyVec);
    end
    advance();
    rst = 1'b0;
    drive(1, 1, 10, 7, 1, 0, 0, LAT_ALU, 0);
    @(negedge clk);
    total++;
    if ({hif.StallD, hif.BusyVec[7]} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_consumer: stall/busy7 got %b want 00", {hif.StallD, hif.BusyVec[7]});
    end
`ifdef HAZARD_STATS_EN
    total++;
    if (hif.StallCycles !== 32'd0) begin
      bad++;
      $display("FAIL midrst_stats: stall count got %0d want 0", hif.StallCycles);
    end
`endif
    advance();
    drive(1, 1, 4, 0, 0, 0, 0, LAT_LOAD, 0);
    advance();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    advance();
    @(negedge clk);
    total++;
    if (hif.StallD !== 1'b0) begin
      bad++;
      $display("FAIL midrst_after_stall: stall got %b want 0", hif.StallD);
    end
`ifdef HAZARD_STATS_EN
    total++;
    if (hif.StallCycles !== 32'd1) begin
      bad++;
      $display("FAIL stats_one_stall: stall count got %0d want 1", hif.StallCycles);
    end
`endif
    advance();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [4:0] exp_v;
      bit st, iss;
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 4) == 0);
      st    = model_stall();
      iss   = !rst && hif.IssueValidD && !st;
      exp_v = {st, !rst && !st, !rst && !st, rst || st, rst || (hif.BranchTakenD && iss)};
      @(negedge clk);
      total++;
      if ({hif.StallD, hif.PCWriteF, hif.IF_IDWriteF, hif.ID_EXBubbleE, hif.IF_IDFlushF}
          !== exp_v) begin
        bad++;
        $display("FAIL rand_ctrl cyc=%0d: got %b want %b", c,
                 {hif.StallD, hif.PCWriteF, hif.IF_IDWriteF, hif.ID_EXBubbleE, hif.IF_IDFlushF},
                 exp_v);
      end
      total++;
      if (hif.BusyVec !== model_busy()) begin
        bad++;
        $display("FAIL rand_busy cyc=%0d: got %h want %h", c, hif.BusyVec, model_busy());
      end
`ifdef HAZARD_STATS_EN
      total++;
      if ({hif.StallCycles, hif.FlushCount} !== {32'(stall_m), 32'(flush_m)}) begin
        bad++;
        $display("FAIL rand_stats cyc=%0d: got %0d/%0d want %0d/%0d", c,
                 hif.StallCycles, hif.FlushCount, stall_m, flush_m);
      end
`endif
      advance();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) pend_m[r] = 0;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_x0();
    test_mul_latency();
    test_branch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule
